// File: rtl/uart_stream_rx.sv
// 8N1 UART receiver feeding a small FIFO that presents received bytes as an
// AXI-Stream-style beat stream (tdata/tlast/tvalid/tready) with error pulses.
module uart_stream_rx #(
  parameter int          CLK_FREQ  = 16000000,
  parameter int          BAUD      = 57600,
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  LAST_CHAR = 8'h0A
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(DEPTH);

  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  logic [1:0]    sync_reg;
  logic          rx_s;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          push;
  logic          frame_err_next;

  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic [8:0]    mem [DEPTH];
  logic          empty, full, pop, wr_en, overrun_next;
  logic          frame_err_reg, overrun_reg;

  // Presetting to 1 keeps a reset release from looking like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], i_uart_rx};
    end
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    push           = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_next   = HALF_LOAD;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (rx_s) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next     = BIT_LOAD;
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          shift_next = {rx_s, shift_reg[7:1]};
          cnt_next   = BIT_LOAD;
          if (bit_idx_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop gives half a bit of slack for the next start edge.
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (rx_s) begin
          push       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          frame_err_next = 1'b1;
          state_next     = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign pop   = !empty && i_tready;
  // A pop in the same cycle frees the slot the push lands in.
  assign wr_en        = push && (!full || pop);
  assign overrun_next = push && full && !pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr_reg[AW-1:0]] <= {(shift_reg == LAST_CHAR), shift_reg};
        wr_ptr_reg              <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign o_tvalid    = !empty;
  assign o_tdata     = mem[rd_ptr_reg[AW-1:0]][7:0];
  assign o_tlast     = mem[rd_ptr_reg[AW-1:0]][8];
  assign o_frame_err = frame_err_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_stream_rx.sv
// Self-checking bench for uart_stream_rx: directed scenarios plus random bytes
// and random sink stalls, checked against a queue-based model of the stream.
module tb_uart_stream_rx;

  localparam int DIV   = 278;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tready = 1'b0;
  logic [7:0] tdata;
  logic       tlast, tvalid, frame_err, overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_stream_rx dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_uart_rx  (rx),
    .o_tdata    (tdata),
    .o_tlast    (tlast),
    .o_tvalid   (tvalid),
    .i_tready   (tready),
    .o_frame_err(frame_err),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: sink stalled, 1: sink always ready, 2: random readiness
  int ready_mode = 1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = ($urandom_range(0, 9) < 7);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes the sink should see, in order, plus error tallies.
  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_ov = 0, got_fe = 0, got_ov = 0;
  int beat_cnt = 0, last_beat_cyc = 0, last_start_cyc = 0;

  function automatic void model_push(input logic [7:0] b);
    if (exp_q.size() >= DEPTH && tready == 1'b0) exp_ov++;
    else exp_q.push_back(b);
  endfunction

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_err) got_fe++;
      if (overrun) got_ov++;
      if (frame_err && overrun) check("err_exclusive", 32'(overrun), 32'(0));
      if (prev_stall) begin
        check("hold_valid", 32'(tvalid), 32'(1));
        check("hold_data", 32'(tdata), 32'(prev_data));
        check("hold_last", 32'(tlast), 32'(prev_last));
      end
      if (tvalid && tready) begin
        logic [7:0] e;
        beat_cnt++;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_beat", 32'(exp_q.size()), 32'(1));
        end else begin
          e = exp_q.pop_front();
          $display("beat tdata=%02h tlast=%0d expected=%02h", tdata, tlast, e);
          check("beat_data", 32'(tdata), 32'(e));
          check("beat_last", 32'(tlast), 32'(e == 8'h0A));
        end
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    last_start_cyc = cyc;
    hold(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(DIV);
    end
    rx = stop_ok;
    if (stop_ok) model_push(b);
    else exp_fe++;
    $display("sent %02h stop=%0d", b, stop_ok);
    hold(DIV);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    hold(2);
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge clk);
    check({tag, "_tvalid"}, 32'(tvalid), 32'(0));
    check({tag, "_tdata"}, 32'(tdata), 32'(0));
    check({tag, "_tlast"}, 32'(tlast), 32'(0));
    check({tag, "_ferr"}, 32'(frame_err), 32'(0));
    check({tag, "_ovr"}, 32'(overrun), 32'(0));
  endtask

  initial begin
    int lat, beats_before;
    logic [7:0] b;

    rst = 1'b1;
    hold(3);
    check_outputs_zero("reset");
    hold(1);
    rst = 1'b0;
    hold(20);

    // 1: single byte and its latency from the start edge
    send_byte(8'h55, 1'b1);
    wait_drain("t1_drain");
    lat = last_beat_cyc - last_start_cyc;
    check("t1_latency", 32'(lat >= 2600 && lat <= 2700), 32'(1));
    check("t1_ferr", 32'(got_fe), 32'(exp_fe));
    check("t1_ovr", 32'(got_ov), 32'(exp_ov));

    // 2: back-to-back frames, second one carries tlast
    send_byte(8'h48, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_drain("t2_drain");

    // 3: short low glitch is a false start
    beats_before = beat_cnt;
    rx = 1'b0;
    hold(50);
    rx = 1'b1;
    hold(3 * DIV);
    check("t3_no_beat", 32'(beat_cnt), 32'(beats_before));
    check("t3_no_ferr", 32'(got_fe), 32'(exp_fe));

    // 4: bad stop bit then long break gives one frame error
    send_byte(8'($urandom), 1'b0);
    hold(20 * DIV);
    rx = 1'b1;
    hold(2 * DIV);
    check("t4_one_ferr", 32'(got_fe), 32'(exp_fe));
    send_byte(8'hA5, 1'b1);
    wait_drain("t4_drain");
    check("t4_ferr_after", 32'(got_fe), 32'(exp_fe));

    // 5: stalled sink overflows the FIFO on the fifth byte
    ready_mode = 0;
    hold(2);
    beats_before = beat_cnt;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    hold(DIV);
    check("t5_ovr_count", 32'(got_ov), 32'(exp_ov));
    check("t5_ovr_is_one", 32'(got_ov), 32'(1));
    check("t5_no_beat_stalled", 32'(beat_cnt), 32'(beats_before));
    ready_mode = 1;
    wait_drain("t5_drain");
    check("t5_beats", 32'(beat_cnt - beats_before), 32'(4));

    // 6: reset in the middle of a frame
    b = 8'h3C;
    rx = 1'b0;
    hold(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      hold(DIV);
    end
    rx = b[4];
    hold(DIV / 2);
    rst = 1'b1;
    hold(2);
    check_outputs_zero("t6_reset");
    hold(1);
    rst = 1'b0;
    rx = 1'b1;
    hold(2 * DIV);
    beats_before = beat_cnt;
    send_byte(8'hC3, 1'b1);
    wait_drain("t6_drain");
    check("t6_one_beat", 32'(beat_cnt - beats_before), 32'(1));

    // Random bytes with a randomly stalling sink
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      send_byte(8'($urandom), 1'b1);
      hold($urandom_range(0, DIV));
    end
    ready_mode = 1;
    wait_drain("rand_drain");
    check("final_ferr", 32'(got_fe), 32'(exp_fe));
    check("final_ovr", 32'(got_ov), 32'(exp_ov));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
